score_regfile: RTL and testbench

SCORE_REGFILE -- requirements
Module: score_regfile

---
 rtl/score_regfile.sv | 214 +++++++++++++++++++++
 tb/tb_score_regfile.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_regfile.sv
// ---------------------------------------------------------------------------
// score_regfile
//
// Four-player score/lives/health register file. Each 32-bit entry is
// {lives[3:0], health[7:0], score[19:0]} where score is five BCD digits.
// Reads are serviced every cycle with one cycle of latency. Updates run
// through a small FSM (IDLE -> ADD x5 -> DMG -> WB) that adds four BCD
// points digits to the score one digit per cycle, applies damage, then
// writes the entry back and pulses upd_ack.
//
// Build option:
//   SCORE_SAT_EN  defined   : carry out of score digit 4 saturates to 99999
//                 undefined : carry out of digit 4 is dropped (mod 100000)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   score_re/addr       read request and player index (addr[4:2]!=0 reads 0)
//   score_data/valid    read data one cycle after score_re, valid strobe
//   upd_req/player/points/damage  update request and operands
//   upd_ack             one-cycle pulse on writeback
//   busy                high from update accept through upd_ack
//   game_over           all four players have zero lives
// ---------------------------------------------------------------------------
module score_regfile #(
    parameter logic [3:0] INIT_LIVES  = 4'd3,
    parameter logic [7:0] INIT_HEALTH = 8'd100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        score_re,
    input  logic [4:0]  score_addr,
    output logic [31:0] score_data,
    output logic        score_valid_data,
    input  logic        upd_req,
    input  logic [1:0]  upd_player,
    input  logic [15:0] upd_points,
    input  logic [7:0]  upd_damage,
    output logic        upd_ack,
    output logic        busy,
    output logic        game_over
);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DMG, S_WB} state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_q [4];
    logic [31:0] mem_d [4];
    logic [31:0] score_data_q, score_data_d;
    logic        score_valid_q, score_valid_d;
    logic        upd_ack_q, upd_ack_d;
    logic        busy_q, busy_d;
    logic        game_over_q, game_over_d;

    // Working copy of the entry being updated
    logic [1:0]  player_q, player_d;
    logic [15:0] points_q, points_d;
    logic [7:0]  damage_q, damage_d;
    logic [3:0]  lives_q, lives_d;
    logic [7:0]  health_q, health_d;
    logic [19:0] score_q, score_d;
    logic [2:0]  digit_q, digit_d;
    logic        carry_q, carry_d;
    logic        dead_q, dead_d;

    logic [31:0] cap_entry;
    logic [3:0]  scr_dig, pts_dig, dig_res;
    logic [4:0]  dsum, dsum_adj;
    logic        dig_carry;

    // Non-BCD points digits are clamped to 9
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    always_comb begin
        state_d       = state_q;
        mem_d         = mem_q;
        score_data_d  = score_data_q;
        score_valid_d = score_re;
        upd_ack_d     = 1'b0;
        busy_d        = busy_q;
        player_d      = player_q;
        points_d      = points_q;
        damage_d      = damage_q;
        lives_d       = lives_q;
        health_d      = health_q;
        score_d       = score_q;
        digit_d       = digit_q;
        carry_d       = carry_q;
        dead_d        = dead_q;
        cap_entry     = mem_q[upd_player];

        // Reads see mem_q, so a read on the writeback edge returns the old entry
        if (score_re) begin
            score_data_d = (|score_addr[4:2]) ? 32'h0 : mem_q[score_addr[1:0]];
        end

        // Current BCD digit pair; points digit 4 is implicitly zero
        case (digit_q)
            3'd0:    begin scr_dig = score_q[3:0];   pts_dig = clamp_digit(points_q[3:0]);   end
            3'd1:    begin scr_dig = score_q[7:4];   pts_dig = clamp_digit(points_q[7:4]);   end
            3'd2:    begin scr_dig = score_q[11:8];  pts_dig = clamp_digit(points_q[11:8]);  end
            3'd3:    begin scr_dig = score_q[15:12]; pts_dig = clamp_digit(points_q[15:12]); end
            3'd4:    begin scr_dig = score_q[19:16]; pts_dig = 4'd0;                         end
            default: begin scr_dig = 4'd0;           pts_dig = 4'd0;                         end
        endcase
        dsum      = {1'b0, scr_dig} + {1'b0, pts_dig} + {4'b0, carry_q};
        dsum_adj  = dsum - 5'd10;
        dig_carry = (dsum > 5'd9);
        dig_res   = dig_carry ? dsum_adj[3:0] : dsum[3:0];

        // busy drops the cycle after the ack pulse
        if (upd_ack_q) busy_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (upd_req && !busy_q) begin
                    player_d = upd_player;
                    points_d = upd_points;
                    damage_d = upd_damage;
                    lives_d  = cap_entry[31:28];
                    health_d = cap_entry[27:20];
                    score_d  = cap_entry[19:0];
                    dead_d   = (cap_entry[31:28] == 4'd0);
                    digit_d  = 3'd0;
                    carry_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                if (!dead_q) begin
                    carry_d = dig_carry;
                    case (digit_q)
                        3'd0:    score_d[3:0]   = dig_res;
                        3'd1:    score_d[7:4]   = dig_res;
                        3'd2:    score_d[11:8]  = dig_res;
                        3'd3:    score_d[15:12] = dig_res;
                        3'd4:    score_d[19:16] = dig_res;
                        default: score_d        = score_q;
                    endcase
                end
                digit_d = digit_q + 3'd1;
                if (digit_q == 3'd4) begin
`ifdef SCORE_SAT_EN
                    if (!dead_q && dig_carry) score_d = 20'h99999;
`endif
                    state_d = S_DMG;
                end
            end
            S_DMG: begin
                if (!dead_q) begin
                    if (damage_q < health_q) begin
                        health_d = health_q - damage_q;
                    end else begin
                        lives_d  = lives_q - 4'd1;
                        // Losing the last life leaves the player at zero health
                        health_d = (lives_q == 4'd1) ? 8'd0 : INIT_HEALTH;
                    end
                end
                state_d = S_WB;
            end
            S_WB: begin
                mem_d[player_q] = {lives_q, health_q, score_q};
                upd_ack_d       = 1'b1;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        game_over_d = (mem_d[0][31:28] == 4'd0) && (mem_d[1][31:28] == 4'd0) &&
                      (mem_d[2][31:28] == 4'd0) && (mem_d[3][31:28] == 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < 4; i++) mem_q[i] <= {INIT_LIVES, INIT_HEALTH, 20'h0};
            score_data_q  <= 32'h0;
            score_valid_q <= 1'b0;
            upd_ack_q     <= 1'b0;
            busy_q        <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_q         <= mem_d;
            score_data_q  <= score_data_d;
            score_valid_q <= score_valid_d;
            upd_ack_q     <= upd_ack_d;
            busy_q        <= busy_d;
            game_over_q   <= game_over_d;
        end
    end

    // Working registers are always loaded on capture before use
    always_ff @(posedge clk) begin
        player_q <= player_d;
        points_q <= points_d;
        damage_q <= damage_d;
        lives_q  <= lives_d;
        health_q <= health_d;
        score_q  <= score_d;
        digit_q  <= digit_d;
        carry_q  <= carry_d;
        dead_q   <= dead_d;
    end

    assign score_data       = score_data_q;
    assign score_valid_data = score_valid_q;
    assign upd_ack          = upd_ack_q;
    assign busy             = busy_q;
    assign game_over        = game_over_q;

endmodule

// File: tb/tb_score_regfile.sv
// Testbench for score_regfile: directed and random updates checked against
// a decimal-arithmetic reference model of the four player entries.
module tb_score_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        score_re = 1'b0;
    logic [4:0]  score_addr = 5'd0;
    logic [31:0] score_data;
    logic        score_valid_data;
    logic        upd_req = 1'b0;
    logic [1:0]  upd_player = 2'd0;
    logic [15:0] upd_points = 16'd0;
    logic [7:0]  upd_damage = 8'd0;
    logic        upd_ack;
    logic        busy;
    logic        game_over;

    score_regfile dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .score_re         (score_re),
        .score_addr       (score_addr),
        .score_data       (score_data),
        .score_valid_data (score_valid_data),
        .upd_req          (upd_req),
        .upd_player       (upd_player),
        .upd_points       (upd_points),
        .upd_damage       (upd_damage),
        .upd_ack          (upd_ack),
        .busy             (busy),
        .game_over        (game_over)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: plain integers, score held as a decimal number
    int m_lives [4];
    int m_health[4];
    int m_score [4];

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int pts_value(input logic [15:0] p);
        int v;
        int d;
        v = 0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(p[i*4 +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_entry(input int p);
        return {4'(m_lives[p]), 8'(m_health[p]), to_bcd(m_score[p])};
    endfunction

    function automatic logic m_game_over();
        return (m_lives[0] == 0) && (m_lives[1] == 0) && (m_lives[2] == 0) && (m_lives[3] == 0);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_lives[i]  = 3;
            m_health[i] = 100;
            m_score[i]  = 0;
        end
    endtask

    task automatic m_apply(input int p, input logic [15:0] pts, input int dmg);
        int s;
        if (m_lives[p] == 0) return;
        s = m_score[p] + pts_value(pts);
        if (s >= 100000) begin
`ifdef SCORE_SAT_EN
            s = 99999;
`else
            s = s - 100000;
`endif
        end
        m_score[p] = s;
        if (dmg < m_health[p]) begin
            m_health[p] = m_health[p] - dmg;
        end else begin
            m_lives[p]  = m_lives[p] - 1;
            m_health[p] = (m_lives[p] == 0) ? 0 : 100;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        score_re   = 1'b1;
        score_addr = a;
        tick();
        score_re = 1'b0;
        chk1({tag, "_vld"}, score_valid_data, 1'b1);
        chk({tag, "_data"}, score_data, exp);
        tick();
        chk1({tag, "_vld_lo"}, score_valid_data, 1'b0);
        chk({tag, "_hold"}, score_data, exp);
    endtask

    // One update; hold keeps upd_req asserted through busy and reads the
    // same player mid-ADD. Every update also reads on the writeback edge.
    task automatic upd(input logic [1:0] p, input logic [15:0] pts, input logic [7:0] dmg,
                       input bit hold, input string tag);
        logic [31:0] old;
        int k;
        bit got;
        old        = m_entry(int'(p));
        upd_req    = 1'b1;
        upd_player = p;
        upd_points = pts;
        upd_damage = dmg;
        tick();
        if (!hold) upd_req = 1'b0;
        chk1({tag, "_busy"}, busy, 1'b1);
        k   = 0;
        got = 1'b0;
        while (!got && k < 12) begin
            if (hold && k == 2) begin score_re = 1'b1; score_addr = {3'b0, p}; end
            if (k == 6)         begin score_re = 1'b1; score_addr = {3'b0, p}; end
            tick();
            k++;
            if (hold && k == 3) begin
                score_re = 1'b0;
                chk({tag, "_rd_add"}, score_data, old);
            end
            if (k == 7) begin
                score_re = 1'b0;
                chk({tag, "_rd_wb"}, score_data, old);
            end
            if (upd_ack === 1'b1) got = 1'b1;
        end
        upd_req  = 1'b0;
        score_re = 1'b0;
        chk({tag, "_lat"}, 32'(k), 32'd7);
        chk1({tag, "_busy_ack"}, busy, 1'b1);
        m_apply(int'(p), pts, int'(dmg));
        chk1({tag, "_go"}, game_over, m_game_over());
        tick();
        chk1({tag, "_ack_lo"}, upd_ack, 1'b0);
        chk1({tag, "_busy_lo"}, busy, 1'b0);
        rd({3'b0, p}, m_entry(int'(p)), {tag, "_rd"});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] wrap_exp;
        int acks;
        int guard;

        // Reset state
        m_reset();
        #2;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ack", upd_ack, 1'b0);
        chk1("rst_vld", score_valid_data, 1'b0);
        chk1("rst_go", game_over, 1'b0);
        chk("rst_data", score_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int a = 0; a < 4; a++) rd(5'(a), 32'h3640_0000, $sformatf("rst_rd%0d", a));
        rd(5'd5, 32'h0, "rd_oob5");
        rd(5'd17, 32'h0, "rd_oob17");

        // Basic BCD add
        upd(2'd1, 16'h0957, 8'd0, 1'b0, "p1_add");
        rd(5'd1, 32'h3640_0957, "p1_const");

        // Drive player 2 to 99990 then overflow digit 4
        for (int i = 0; i < 10; i++) upd(2'd2, 16'h9999, 8'd0, 1'b0, $sformatf("p2_fill%0d", i));
        rd(5'd2, 32'h3649_9990, "p2_99990");
        upd(2'd2, 16'h0025, 8'd0, 1'b0, "p2_wrap");
`ifdef SCORE_SAT_EN
        wrap_exp = 20'h99999;
`else
        wrap_exp = 20'h00015;
`endif
        rd(5'd2, {4'd3, 8'd100, wrap_exp}, "p2_wrap_const");

        // upd_req held through busy; same-player read during ADD
        upd(2'd3, 16'h1234, 8'd30, 1'b1, "p3_hold");
        rd(5'd3, 32'h3460_1234, "p3_once");

        // Life loss down to zero, then a dead player is left alone
        upd(2'd0, 16'h0000, 8'd150, 1'b0, "p0_dmg1");
        rd(5'd0, 32'h2640_0000, "p0_l2");
        upd(2'd0, 16'h0000, 8'd150, 1'b0, "p0_dmg2");
        upd(2'd0, 16'h0000, 8'd150, 1'b0, "p0_dmg3");
        rd(5'd0, 32'h0000_0000, "p0_dead");
        upd(2'd0, 16'h0100, 8'd5, 1'b0, "p0_dead_upd");
        rd(5'd0, 32'h0000_0000, "p0_still");

        // Non-BCD points digits clamp to 9: 957 + 9093
        upd(2'd1, 16'hA0F3, 8'd0, 1'b0, "p1_clamp");
        rd(5'd1, 32'h3641_0050, "p1_clamp_const");

        // Random updates
        for (int i = 0; i < 15; i++) begin
            upd(2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom_range(0, 255)), 1'b0,
                $sformatf("rnd%0d", i));
        end

        // Everybody to zero lives
        for (int p = 0; p < 4; p++) begin
            guard = 0;
            while (m_lives[p] > 0 && guard < 8) begin
                upd(2'(p), 16'h0001, 8'd255, 1'b0, $sformatf("kill%0d_%0d", p, guard));
                guard++;
            end
        end
        chk1("game_over_final", game_over, 1'b1);

        // Reset in the middle of ADD
        upd_req    = 1'b1;
        upd_player = 2'd1;
        upd_points = 16'h0001;
        upd_damage = 8'd0;
        tick();
        upd_req = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_ack", upd_ack, 1'b0);
        chk1("mid_rst_go", game_over, 1'b0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (upd_ack === 1'b1) acks++;
        end
        chk("mid_rst_no_ack", 32'(acks), 32'd0);
        for (int a = 0; a < 4; a++) rd(5'(a), 32'h3640_0000, $sformatf("post_rst_rd%0d", a));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
